// File: rtl/conv_deinterleaver_pkg.sv
// Shared constants and helpers for the convolutional (Forney) deinterleaver.
// Functions take NB/M so each parameterised instance derives its own sizes;
// the localparams below describe the default configuration.
package conv_deinterleaver_pkg;

  localparam int DEF_W  = 12;
  localparam int DEF_NB = 12;
  localparam int DEF_M  = 17;

  // Total delay cells across all branches: M * NB*(NB-1)/2.
  function automatic int total_cells(input int nb, input int m);
    return m * nb * (nb - 1) / 2;
  endfunction

  // Accepted words needed before every branch delay line has been filled.
  function automatic int prime_cnt(input int nb, input int m);
    return nb * (nb - 1) * m;
  endfunction

  // Address width that never collapses to zero bits.
  function automatic int addr_width(input int cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

  // First RAM cell of branch j: M * sum_{i<j} (NB-1-i).
  function automatic int branch_base(input int nb, input int m, input int j);
    int acc;
    acc = 0;
    for (int i = 0; i < j; i++) acc += nb - 1 - i;
    return m * acc;
  endfunction

  localparam int TOTAL_CELLS = total_cells(DEF_NB, DEF_M);
  localparam int ADDR_W      = addr_width(TOTAL_CELLS);
  localparam int BR_W        = $clog2(DEF_NB);
  localparam int PRIME_CNT   = prime_cnt(DEF_NB, DEF_M);

  // Where the registered output word comes from.
  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,  // after reset, nothing accepted yet
    SRC_RAM    = 2'd1,  // delayed branch, old cell value
    SRC_BYPASS = 2'd2   // last branch, zero delay
  } out_src_e;

endpackage

// File: rtl/conv_deinterleaver_ram.sv
// Single-port delay-line storage shared by all delayed branches.
// Read-before-write: an enabled access returns the old cell and stores the new word.
module deint_ram
  import conv_deinterleaver_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = TOTAL_CELLS,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Access the addressed cell: capture old contents, then overwrite.
  // NOTE: the array has no reset; clearing it would force flops instead of RAM,
  // and its contents are meaningless until the delay lines have been filled.
  always_ff @(posedge clk) begin
    if (en) begin
      r_rdata     <= r_mem[addr];
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/conv_deinterleaver.sv
// Forney convolutional deinterleaver: NB branches, branch j delayed by
// (NB-1-j)*M words of that branch, all delay lines packed into one RAM.
// Optional feature: define DEINT_SYNC_CHECK_EN to count syncs that arrive
// while the commutator is not at branch 0 (sync_err_cnt, saturating at 255).
module conv_deinterleaver
  import conv_deinterleaver_pkg::*;
#(
  parameter int W  = 12,
  parameter int NB = 12,
  parameter int M  = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_sync,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_sync,
  output logic         primed,
  output logic [7:0]   sync_err_cnt
);

  localparam int CELLS = total_cells(NB, M);
  localparam int AW    = addr_width(CELLS);
  localparam int BW    = $clog2(NB);
  localparam int PRIME = prime_cnt(NB, M);
  localparam int PCW   = $clog2(PRIME + 1);
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  logic [BW-1:0]  r_comm;
  logic [AW-1:0]  r_ptr [NB];
  logic [PCW-1:0] r_prime_cnt;
  logic           r_primed;
  logic           r_out_valid;
  logic           r_out_sync;
  logic [W-1:0]   r_bypass;
  out_src_e       r_src;

  logic           w_sync_acc;
  logic [BW-1:0]  w_branch;
  logic           w_is_last;
  logic           w_ram_en;
  logic [AW-1:0]  w_addr;
  logic [W-1:0]   w_ram_rd;
  logic [AW-1:0]  w_base_lut [NB];
  logic [AW-1:0]  w_lim_lut  [NB];

  // Per-branch RAM base and last pointer value, fixed at elaboration.
  for (genvar j = 0; j < NB; j++) begin : g_lut
    assign w_base_lut[j] = AW'(branch_base(NB, M, j));
    assign w_lim_lut[j]  = (j == NB - 1) ? '0 : AW'((NB - 1 - j) * M - 1);
  end

  // An accepted sync forces the current word onto branch 0.
  assign w_sync_acc = in_valid & in_sync;
  assign w_branch   = w_sync_acc ? '0 : r_comm;
  assign w_is_last  = (w_branch == LAST);
  assign w_ram_en   = in_valid & ~w_is_last;
  assign w_addr     = w_base_lut[w_branch] + r_ptr[w_branch];

  deint_ram #(
    .W     (W),
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .addr  (w_addr),
    .wdata (in_data),
    .rdata (w_ram_rd)
  );

  // Commutator: step one branch per accepted word, hold otherwise.
  // NOTE: all clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_comm <= '0;
    end else if (in_valid) begin
      r_comm <= (w_branch == LAST) ? '0 : w_branch + BW'(1);
    end
  end

  // Circular pointer of the addressed branch advances only on its own word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NB; j++) r_ptr[j] <= '0;
    end else if (w_ram_en) begin
      for (int j = 0; j < NB - 1; j++) begin
        if (w_branch == BW'(j)) begin
          r_ptr[j] <= (r_ptr[j] == w_lim_lut[j]) ? '0 : r_ptr[j] + AW'(1);
        end
      end
    end
  end

  // Fill counter; primed reflects whether the lines were full before this word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prime_cnt <= '0;
      r_primed    <= 1'b0;
    end else if (in_valid) begin
      r_primed <= ~in_sync & (r_prime_cnt == PCW'(PRIME));
      if (in_sync) begin
        r_prime_cnt <= PCW'(1);
      end else if (r_prime_cnt != PCW'(PRIME)) begin
        r_prime_cnt <= r_prime_cnt + PCW'(1);
      end
    end
  end

  // Output qualifiers and source selection, one clock after the input word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sync  <= 1'b0;
      r_bypass    <= '0;
      r_src       <= SRC_ZERO;
    end else begin
      r_out_valid <= in_valid;
      r_out_sync  <= in_valid & (w_branch == '0);
      if (in_valid) begin
        r_src <= w_is_last ? SRC_BYPASS : SRC_RAM;
        if (w_is_last) r_bypass <= in_data;
      end
    end
  end

  // Select the registered word; both sources hold while no word is accepted.
  // NOTE: default assigned first so no path leaves out_data unassigned (no latch).
  always_comb begin
    out_data = '0;
    unique case (r_src)
      SRC_RAM:    out_data = w_ram_rd;
      SRC_BYPASS: out_data = r_bypass;
      default:    out_data = '0;
    endcase
  end

  assign out_valid = r_out_valid;
  assign out_sync  = r_out_sync;
  assign primed    = r_primed;

`ifdef DEINT_SYNC_CHECK_EN
  logic [7:0] r_sync_err;

  // Count accepted syncs that land while the commutator is off branch 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync_err <= '0;
    end else if (w_sync_acc && (r_comm != '0) && (r_sync_err != 8'hFF)) begin
      r_sync_err <= r_sync_err + 8'd1;
    end
  end

  assign sync_err_cnt = r_sync_err;
`else
  assign sync_err_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_deinterleaver.sv
// Directed bench for conv_deinterleaver: a small NB=3/M=2 instance for the
// timing cases and a default-size instance against a history-based reference.
module tb_conv_deinterleaver;

  localparam int W  = 12;
  localparam int NB = 3;
  localparam int M  = 2;
  localparam int BIG_NB = 12;
  localparam int BIG_M  = 17;
  localparam int BIG_N  = 5000;
  localparam int BIG_PRIME = BIG_NB * (BIG_NB - 1) * BIG_M;

`ifdef DEINT_SYNC_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_sync = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_sync;
  logic         primed;
  logic [7:0]   sync_err_cnt;

  logic         b_in_valid = 1'b0;
  logic [W-1:0] b_in_data = '0;
  logic         b_in_sync = 1'b0;
  logic         b_out_valid;
  logic [W-1:0] b_out_data;
  logic         b_out_sync;
  logic         b_primed;
  logic [7:0]   b_sync_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv_deinterleaver #(.W(W), .NB(NB), .M(M)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_sync      (in_sync),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_sync     (out_sync),
    .primed       (primed),
    .sync_err_cnt (sync_err_cnt)
  );

  conv_deinterleaver #(.W(W), .NB(BIG_NB), .M(BIG_M)) u_big (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (b_in_valid),
    .in_data      (b_in_data),
    .in_sync      (b_in_sync),
    .out_valid    (b_out_valid),
    .out_data     (b_out_data),
    .out_sync     (b_out_sync),
    .primed       (b_primed),
    .sync_err_cnt (b_sync_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one input cycle to the small DUT; return 1 ns after the edge.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"},  out_data, 0);
    check({tag, "_sync"},  out_sync, 0);
    check({tag, "_primed"}, primed, 0);
    check({tag, "_err"},   sync_err_cnt, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    check_all_zero("reset");
  endtask

  // Words base+0 .. base+n-1, sync on the first; optional idle every third cycle
  // (with in_sync raised, which must be ignored).
  task automatic run_stream(input string tag, input int n, input int base, input bit gaps);
    int k;
    int cyc;
    int exp_d;
    int last_exp;
    bit have_exp;
    k = 0;
    cyc = 0;
    last_exp = 0;
    have_exp = 1'b0;
    while (k < n) begin
      if (gaps && (cyc % 3 == 2)) begin
        drive(1'b0, 1'b1, 12'hABC);
        check($sformatf("%s_gap%0d_valid", tag, cyc), out_valid, 0);
        if (have_exp) check($sformatf("%s_gap%0d_hold", tag, cyc), out_data, last_exp);
      end else begin
        drive(1'b1, (k == 0), W'(base + k));
        check($sformatf("%s_w%0d_valid", tag, k), out_valid, 1);
        check($sformatf("%s_w%0d_sync", tag, k), out_sync, (k % 3 == 0));
        check($sformatf("%s_w%0d_primed", tag, k), primed, (k >= 12));
        if (k >= 12) begin
          case (k % 3)
            0:       exp_d = base + k - 12;
            1:       exp_d = base + k - 6;
            default: exp_d = base + k;
          endcase
          check($sformatf("%s_w%0d_data", tag, k), out_data, exp_d);
          last_exp = exp_d;
          have_exp = 1'b1;
        end
        k++;
      end
      cyc++;
    end
  endtask

  logic [W-1:0] hist [BIG_N];

  initial begin
    int j;
    do_reset();

    // Continuous stream, sync on word 0.
    run_stream("cont", 24, 0, 1'b0);

    // Same stream with an idle cycle every third cycle.
    do_reset();
    run_stream("gaps", 24, 0, 1'b1);

    // Misaligned sync at word 13 (commutator at branch 1).
    do_reset();
    run_stream("pre", 13, 0, 1'b0);
    drive(1'b1, 1'b1, W'(13));
    check("mis_w13_sync", out_sync, 1);
    check("mis_w13_data", out_data, 3);
    check("mis_w13_primed", primed, 0);
    check("mis_w13_err", sync_err_cnt, ERR_EXP);
    drive(1'b1, 1'b0, W'(14));
    check("mis_w14_sync", out_sync, 0);
    check("mis_w14_data", out_data, 7);
    check("mis_w14_primed", primed, 0);

    // Reset in the middle of a stream, then restart.
    do_reset();
    run_stream("run", 20, 0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, W'(20));
    rst_n = 1'b1;
    check_all_zero("midrst");
    run_stream("restart", 24, 100, 1'b0);

`ifdef DEINT_SYNC_CHECK_EN
    // 300 misaligned syncs saturate the error counter.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, '0);
      drive(1'b1, 1'b1, '0);
    end
    check("err_saturate", sync_err_cnt, 255);
`endif

    in_valid = 1'b0;
    in_sync  = 1'b0;

    // Default geometry: random words, sync every 12, compare after fill.
    for (int k = 0; k < BIG_N; k++) begin
      b_in_valid = 1'b1;
      b_in_sync  = (k % BIG_NB == 0);
      b_in_data  = W'($urandom_range(0, 4095));
      hist[k]    = b_in_data;
      @(posedge clk);
      #1;
      j = k % BIG_NB;
      check($sformatf("big_w%0d_sync", k), b_out_sync, (j == 0));
      if (k >= BIG_PRIME) begin
        check($sformatf("big_w%0d_data", k), b_out_data,
              hist[k - (BIG_NB - 1 - j) * BIG_M * BIG_NB]);
      end
    end
    b_in_valid = 1'b0;
    b_in_sync  = 1'b0;
    @(posedge clk);
    #1;
    check("big_idle_valid", b_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
